// File: rtl/rv_mem_pkg.sv
// Shared encodings for the memory stage: write-back select codes, funct3
// access codes, the LSU state type and an access-size decode helper.
package rv_mem_pkg;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  // Unsigned funct3 codes only exist for loads; a store with any code other
  // than SB/SH is a word store.
  function automatic acc_size_t access_size(input logic is_store, input logic [2:0] f3);
    acc_size_t sz;
    sz = SZ_W;
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) begin
      sz = SZ_B;
    end else if (f3 == F3_H || (!is_store && f3 == F3_HU)) begin
      sz = SZ_H;
    end else if (f3 == F3_W) begin
      sz = SZ_W;
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment and extension.
// Ports:
//   rdata  : 32-bit word returned by data memory
//   addr   : byte offset within the word
//   funct3 : load size/sign code
//   ext    : lane-selected, sign/zero-extended result
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{addr, 3'b000} +: 8];
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   ext = {24'd0, w_byte};
      F3_H:    ext = {{16{w_half[15]}}, w_half};
      F3_HU:   ext = {16'd0, w_half};
      F3_W:    ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit. Issues loads and stores on a req/ack data
// bus with variable latency, stalls upstream while an access is in flight,
// and produces the registered MEM/WB payload.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   alu, pc, rs2, rd            : EX/MEM payload (address, PC, store data, rd)
//   WBsel, RegWEn, memRW, funct3: write-back select, reg write, store, size
//   dmem_req/we/addr/wdata/be   : data bus request fields (held until ack)
//   dmem_ack, dmem_rdata        : bus completion pulse and read word
//   stall                       : hold upstream stages (combinational)
//   wb_data, wb_rd, wb_RegWEn   : registered MEM/WB payload
//   misalign, bus_err           : registered one-cycle fault pulses
module mem_stage_lsu
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu,
  input  logic [31:0] pc,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  input  logic [1:0]  WBsel,
  input  logic        RegWEn,
  input  logic        memRW,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWEn,
  output logic        misalign,
  output logic        bus_err
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_lane;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we, r_misal, r_berr;

  logic        w_load, w_access, w_misal, w_latch;
  acc_size_t   w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [31:0] w_wb_data_nxt;
  logic [4:0]  w_wb_rd_nxt;
  logic        w_wb_we_nxt, w_misal_nxt, w_berr_nxt;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .addr   (r_lane),
    .funct3 (r_f3),
    .ext    (w_ext)
  );

  // Access decode and bus field formation from the live EX/MEM inputs.
  always_comb begin
    w_load   = !memRW && RegWEn && (WBsel == WB_MEM);
    w_access = memRW || w_load;
    w_size   = access_size(memRW, funct3);
    w_misal  = 1'b0;
    w_be     = 4'b1111;
    w_wdata  = rs2;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << alu[1:0];
        w_wdata = {4{rs2[7:0]}};
      end
      SZ_H: begin
        w_misal = alu[0];
        w_be    = alu[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{rs2[15:0]}};
      end
      default: begin
        w_misal = (alu[1:0] != 2'b00);
      end
    endcase
  end

  // Next-state and MEM/WB payload; anything not written explicitly is a bubble.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_latch       = 1'b0;
    stall         = 1'b0;
    w_wb_data_nxt = '0;
    w_wb_rd_nxt   = '0;
    w_wb_we_nxt   = 1'b0;
    w_misal_nxt   = 1'b0;
    w_berr_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_access) begin
          case (WBsel)
            WB_PC4:  w_wb_data_nxt = pc + 32'd4;
            WB_ALU:  w_wb_data_nxt = alu;
            default: w_wb_data_nxt = alu;
          endcase
          w_wb_rd_nxt = rd;
          w_wb_we_nxt = RegWEn;
        end else if (w_misal) begin
          w_misal_nxt = 1'b1;
        end else begin
          stall       = 1'b1;
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall     = !dmem_ack;
        w_cnt_nxt = r_cnt + 8'd1;
        if (dmem_ack) begin
          w_state_nxt = IDLE;
          if (!r_we) begin
            w_wb_data_nxt = w_ext;
            w_wb_rd_nxt   = r_rd;
            w_wb_we_nxt   = 1'b1;
          end
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          // Abort: release upstream in this final cycle and flag the error.
          stall       = 1'b0;
          w_berr_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_lane    <= '0;
      r_f3      <= '0;
      r_rd      <= '0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
      r_misal   <= 1'b0;
      r_berr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_wb_rd   <= w_wb_rd_nxt;
      r_wb_we   <= w_wb_we_nxt;
      r_misal   <= w_misal_nxt;
      r_berr    <= w_berr_nxt;
      if (w_latch) begin
        r_we    <= memRW;
        r_addr  <= {alu[31:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_lane  <= alu[1:0];
        r_f3    <= funct3;
        r_rd    <= rd;
      end
    end
  end

  assign dmem_req   = (r_state == BUSY);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign wb_data    = r_wb_data;
  assign wb_rd      = r_wb_rd;
  assign wb_RegWEn  = r_wb_we;
  assign misalign   = r_misal;
  assign bus_err    = r_berr;

endmodule
